// File: rtl/mem_lsu.sv
// MEM stage load/store unit: passes ALU results through, runs req/ack data-bus
// transactions for loads and stores, and stalls the pipeline until data is ready.
module mem_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_sdata,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    output logic [31:0] mem_wdata,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic        stallreq,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [31:0] rdata_r;

    logic        is_load_s;
    logic        is_store_s;
    logic        misalign_s;
    logic [3:0]  sel_s;
    logic [31:0] sdata_s;
    logic [31:0] ldata_s;

    function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] a);
        logic [3:0] sel;
        case (op)
            OP_SB:   sel = 4'b0001 << a;
            OP_SH:   sel = a[1] ? 4'b1100 : 4'b0011;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] d);
        logic [31:0] r;
        case (op)
            OP_SB:   r = {4{d[7:0]}};
            OP_SH:   r = {2{d[15:0]}};
            OP_SW:   r = d;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] a,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'd0, h};
            OP_LW:   r = d;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Decode the EX/MEM op into access class, alignment fault and bus lane data
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        misalign_s = 1'b0;
        case (ex_op)
            OP_LB, OP_LBU: is_load_s = 1'b1;
            OP_LH, OP_LHU: begin
                is_load_s  = 1'b1;
                misalign_s = ex_addr[0];
            end
            OP_LW: begin
                is_load_s  = 1'b1;
                misalign_s = (ex_addr[1:0] != 2'b00);
            end
            OP_SB: is_store_s = 1'b1;
            OP_SH: begin
                is_store_s = 1'b1;
                misalign_s = ex_addr[0];
            end
            OP_SW: begin
                is_store_s = 1'b1;
                misalign_s = (ex_addr[1:0] != 2'b00);
            end
            default: begin
                is_load_s  = 1'b0;
                is_store_s = 1'b0;
            end
        endcase
        sel_s   = lane_sel(ex_op, ex_addr[1:0]);
        sdata_s = store_data(ex_op, ex_sdata);
        ldata_s = load_extract(ex_op, ex_addr[1:0], rdata_r);
    end

    assign misalign = misalign_s;

    // Transaction sequencer; bus_err doubles as the "timed out" marker during DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 8'd0;
            rdata_r   <= 32'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_err   <= 1'b0;
            bus_addr  <= 32'd0;
            bus_sel   <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    bus_err <= 1'b0;
                    if ((is_load_s || is_store_s) && !misalign_s) begin
                        bus_req   <= 1'b1;
                        bus_we    <= is_store_s;
                        bus_addr  <= {ex_addr[31:2], 2'b00};
                        bus_sel   <= sel_s;
                        bus_wdata <= sdata_s;
                        cnt_r     <= 8'd0;
                        state_r   <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        rdata_r <= bus_rdata;
                        bus_req <= 1'b0;
                        state_r <= DONE;
                    end else if (cnt_r == 8'(TIMEOUT - 1)) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                DONE: begin
                    bus_err <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    bus_req <= 1'b0;
                    bus_err <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Write-back triple and stall request towards the pipeline
    always_comb begin
        mem_wdata = ex_wdata;
        mem_wd    = ex_wd;
        mem_wreg  = ex_wreg;
        stallreq  = 1'b0;
        case (state_r)
            IDLE: begin
                if (misalign_s) begin
                    mem_wreg = 1'b0;
                end else if (is_load_s || is_store_s) begin
                    stallreq = 1'b1;
                    mem_wreg = 1'b0;
                end else begin
                    mem_wreg = ex_wreg;
                end
            end
            BUSY: begin
                stallreq = 1'b1;
                mem_wreg = 1'b0;
            end
            DONE: begin
                if (is_load_s && !bus_err) begin
                    mem_wdata = ldata_s;
                    mem_wreg  = ex_wreg;
                end else begin
                    mem_wdata = 32'd0;
                    mem_wreg  = 1'b0;
                end
            end
            default: begin
                stallreq = 1'b0;
                mem_wreg = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized self-checking bench for mem_lsu against a transaction-level model.
module tb_mem_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ex_op;
    logic [31:0] ex_addr, ex_sdata, ex_wdata;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg, stallreq, misalign, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_sel;
    logic        bus_ack;

    int n_cmp = 0;
    int n_err = 0;

    mem_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ex_op(ex_op), .ex_addr(ex_addr), .ex_sdata(ex_sdata),
        .ex_wdata(ex_wdata), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .mem_wdata(mem_wdata),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .stallreq(stallreq), .misalign(misalign),
        .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_sel(bus_sel), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Access size in bytes (0 = not a memory op)
    function automatic int op_size(input int op);
        case (op)
            1, 2, 6: return 1;
            3, 4, 7: return 2;
            5, 8:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit op_store(input int op);
        return (op >= 6) && (op <= 8);
    endfunction

    // Expected register value for a completed load
    function automatic logic [31:0] model_load(input int op, input logic [31:0] a,
                                               input logic [31:0] rd);
        int unsigned sz = op_size(op);
        int unsigned off = (sz == 2) ? (a % 4) / 2 * 2 : a % 4;
        longint unsigned v;
        if (sz == 4) return rd;
        v = (rd >> (8 * off)) % (64'd1 << (8 * sz));
        if ((op == 1 || op == 3) && v >= (64'd1 << (8 * sz - 1)))
            v = v + 64'h1_0000_0000 - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_sel(input int op, input logic [31:0] a);
        int unsigned s;
        case (op)
            6:       s = 1 << (a % 4);
            7:       s = 3 << (a % 4);
            default: s = 15;
        endcase
        return s[3:0];
    endfunction

    function automatic logic [31:0] model_sdata(input int op, input logic [31:0] d);
        case (op)
            6:       return (d % 256) * 32'h0101_0101;
            7:       return (d % 65536) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    // Run one instruction through the stage; w = ack wait cycles (>= TO means never)
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] wd32, input logic [4:0] wd, input logic wreg,
                          input int w, input logic [31:0] rd);
        int  sz  = op_size(op);
        bit  mis = (sz != 0) && (a % sz != 0);
        bit  mem = (sz != 0) && !mis;
        bit  to  = (w >= TO);
        bit  acked = 1'b0;
        ex_op = op[3:0]; ex_addr = a; ex_sdata = sd; ex_wdata = wd32; ex_wd = wd; ex_wreg = wreg;
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        @(negedge clk);
        check_eq("idle_misalign", 32'(misalign), 32'(mis));
        check_eq("idle_stall", 32'(stallreq), 32'(mem));
        check_eq("idle_req", 32'(bus_req), 32'd0);
        if (!mem) begin
            check_eq("idle_wreg", 32'(mem_wreg), mis ? 32'd0 : 32'(wreg));
            check_eq("idle_wd", 32'(mem_wd), 32'(wd));
            if (!mis) check_eq("idle_wdata", mem_wdata, wd32);
            @(posedge clk); #1;
            bus_ack = 1'b0;
            return;
        end
        check_eq("idle_wreg", 32'(mem_wreg), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < TO; k++) begin
            bus_ack = (k == w);
            bus_rdata = (k == w) ? rd : $urandom;
            @(negedge clk);
            check_eq("busy_req", 32'(bus_req), 32'd1);
            check_eq("busy_stall", 32'(stallreq), 32'd1);
            check_eq("busy_wreg", 32'(mem_wreg), 32'd0);
            if (k == 0) begin
                check_eq("bus_we", 32'(bus_we), 32'(op_store(op)));
                check_eq("bus_addr", bus_addr, a - a % 4);
                check_eq("bus_sel", 32'(bus_sel), 32'(model_sel(op, a)));
                if (op_store(op)) check_eq("bus_wdata", bus_wdata, model_sdata(op, sd));
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
            if (k == w) begin
                acked = 1'b1;
                break;
            end
        end
        check_eq("acked", 32'(acked), 32'(!to));
        bus_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_eq("done_stall", 32'(stallreq), 32'd0);
        check_eq("done_req", 32'(bus_req), 32'd0);
        check_eq("done_err", 32'(bus_err), 32'(to));
        check_eq("done_wd", 32'(mem_wd), 32'(wd));
        check_eq("done_wreg", 32'(mem_wreg), (!to && !op_store(op)) ? 32'(wreg) : 32'd0);
        if (!to) check_eq("done_wdata", mem_wdata,
                          op_store(op) ? 32'd0 : model_load(op, a, rd));
        @(posedge clk); #1;
        bus_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ex_op = 4'd0; ex_addr = 32'd0; ex_sdata = 32'd0; ex_wdata = 32'd0;
        ex_wd = 5'd0; ex_wreg = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", 32'(bus_req), 32'd0);
        check_eq("rst_we", 32'(bus_we), 32'd0);
        check_eq("rst_err", 32'(bus_err), 32'd0);
        check_eq("rst_addr", bus_addr, 32'd0);
        check_eq("rst_sel", 32'(bus_sel), 32'd0);
        check_eq("rst_wdata", bus_wdata, 32'd0);
        check_eq("rst_stall", 32'(stallreq), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(0, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 0, 32'h0);
        run_op(1, 32'h103, 32'h0, 32'h0, 5'd9, 1'b1, 0, 32'h80FF_0011);
        run_op(7, 32'h202, 32'hAAAA_BEEF, 32'h0, 5'd3, 1'b1, 3, 32'h0);
        run_op(5, 32'h301, 32'h0, 32'h0, 5'd4, 1'b1, 0, 32'h0);
        run_op(4, 32'h400, 32'h0, 32'h0, 5'd6, 1'b1, 99, 32'h0);

        // Reset in the middle of an LW, followed by a late ack
        ex_op = 4'd5; ex_addr = 32'h500; ex_wd = 5'd7; ex_wreg = 1'b1; bus_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rstx_busy_req", 32'(bus_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstx_wreg", 32'(mem_wreg), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; ex_op = 4'd0; ex_wreg = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("rstx_req", 32'(bus_req), 32'd0);
        check_eq("rstx_stall", 32'(stallreq), 32'd0);
        check_eq("rstx_wreg2", 32'(mem_wreg), 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check_eq("rstx_req2", 32'(bus_req), 32'd0);
        check_eq("rstx_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 250; i++) begin
            int op = $urandom_range(0, 15);
            logic [31:0] a = $urandom;
            int sz = op_size(op);
            int w = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 1)
                                                : $urandom_range(0, TO - 1);
            if (sz != 0 && $urandom_range(0, 3) != 0) a = a - a % sz;
            run_op(op, a, $urandom, $urandom, 5'($urandom), 1'($urandom), w, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
